seq_timing_gen: RTL and testbench

- Parametrised successor to the basic-computer sequence counter (SC).
- Holds a binary step counter SQ and decodes it into one-hot timing signals T[N_STEPS-1:0] for the control unit.
- Adds the following over SC:
  - configurable step count and a runtime end step;
  - wrap or saturate mode;
  - parallel load;
  - single-step (debug) mode;
  - terminal-count, wrap and error status.

---
 rtl/seq_timing_gen_if.sv | 44 ++++
 rtl/seq_timing_gen.sv | 96 +++++++++
 tb/tb_seq_timing_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_timing_gen_if.sv
// ============================================================================
// Module      : seq_timing_gen_if
// Description : Control/status bundle for seq_timing_gen. The master side is
//               the control unit driving run/clear/increment/load/step
//               requests. The slave side is the timing generator, which
//               returns the step counter, its one-hot decode and status.
//   Signals   : S, CLR, INR, LD, LD_VAL[CW], LIMIT[CW], STEP_MODE, STEP_GO
//               (master -> slave); SQ[CW], T[N_STEPS], tc, wrap, err
//               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_timing_gen_if #(
  parameter int N_STEPS = 16
);
  localparam int CW = (N_STEPS > 2) ? $clog2(N_STEPS) : 1;

  logic               S;
  logic               CLR;
  logic               INR;
  logic               LD;
  logic [CW-1:0]      LD_VAL;
  logic [CW-1:0]      LIMIT;
  logic               STEP_MODE;
  logic               STEP_GO;
  logic [CW-1:0]      SQ;
  logic [N_STEPS-1:0] T;
  logic               tc;
  logic               wrap;
  logic               err;

  modport master (
    output S, CLR, INR, LD, LD_VAL, LIMIT, STEP_MODE, STEP_GO,
    input  SQ, T, tc, wrap, err
  );

  modport slave (
    input  S, CLR, INR, LD, LD_VAL, LIMIT, STEP_MODE, STEP_GO,
    output SQ, T, tc, wrap, err
  );
endinterface

`default_nettype wire

// File: rtl/seq_timing_gen.sv
// ============================================================================
// Module      : seq_timing_gen
// Description : Parametrised sequence counter. It holds a binary step count SQ
//               and decodes it into one-hot timing strobes T. It also provides
//               a runtime end step, wrap/saturate behaviour, parallel load,
//               single-step debug mode and terminal-count/wrap/error status.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : seq_timing_gen_if slave modport (controls in, SQ/T/status out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_timing_gen #(
  parameter int N_STEPS    = 16,
  parameter int SATURATE   = 0,
  parameter int RESET_STEP = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_timing_gen_if.slave bus
);

  localparam int            CW       = (N_STEPS > 2) ? $clog2(N_STEPS) : 1;
  localparam logic [CW-1:0] MAX_STEP = CW'(N_STEPS - 1);
  localparam logic [CW-1:0] RST_SQ   = CW'(RESET_STEP);

  logic [CW-1:0] sq;
  logic          wrap_q;
  logic          err_q;
  logic          step_go_q;
  logic          step_armed;
  logic [CW-1:0] lim;
  logic          step_pulse;
  logic          adv;

  // Clamp the runtime end step to the last implemented step.
  assign lim = (bus.LIMIT > MAX_STEP) ? MAX_STEP : bus.LIMIT;

  // step_armed stays low after reset until STEP_GO has been seen low.
  // Without it, a strobe held high through reset release would look like a
  // fresh rising edge, because step_go_q restarts at 0.
  assign step_pulse = bus.STEP_GO & ~step_go_q & step_armed;
  assign adv        = bus.S & bus.INR & (~bus.STEP_MODE | step_pulse);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq         <= RST_SQ;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      step_go_q  <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      // The edge detector runs even while S=0, so a strobe that rises while
      // the counter is frozen is consumed rather than deferred.
      step_go_q <= bus.STEP_GO;
      if (!bus.STEP_GO) begin
        step_armed <= 1'b1;
      end
      wrap_q <= 1'b0;
      if (bus.S) begin
        if (bus.CLR) begin
          sq    <= '0;
          err_q <= 1'b0;
        end else if (bus.LD) begin
          if (bus.LD_VAL <= lim) begin
            sq <= bus.LD_VAL;
          end else begin
            sq    <= lim;
            err_q <= 1'b1;
          end
        end else if (adv) begin
          // Using >= means a count left above a newly lowered limit
          // terminates on the next increment.
          if (sq < lim) begin
            sq <= sq + CW'(1);
          end else if (SATURATE != 0) begin
            err_q <= 1'b1;
          end else begin
            sq     <= '0;
            wrap_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.SQ   = sq;
  assign bus.T    = {{(N_STEPS-1){1'b0}}, 1'b1} << sq;
  assign bus.tc   = (sq == lim);
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_timing_gen.sv
// ============================================================================
// Module      : tb_seq_timing_gen
// Description : Directed testbench for seq_timing_gen. dut_a is a wrapping
//               instance and dut_b is a saturating instance. Both have 16
//               steps and reset to step 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vecs  = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  seq_timing_gen_if #(.N_STEPS(16)) bus_a ();
  seq_timing_gen_if #(.N_STEPS(16)) bus_b ();

  seq_timing_gen #(.N_STEPS(16), .SATURATE(0), .RESET_STEP(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  seq_timing_gen #(.N_STEPS(16), .SATURATE(1), .RESET_STEP(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.S = 0; bus_a.CLR = 0; bus_a.INR = 0; bus_a.LD = 0; bus_a.LD_VAL = 0;
    bus_a.LIMIT = 15; bus_a.STEP_MODE = 0; bus_a.STEP_GO = 0;
    bus_b.S = 0; bus_b.CLR = 0; bus_b.INR = 0; bus_b.LD = 0; bus_b.LD_VAL = 0;
    bus_b.LIMIT = 15; bus_b.STEP_MODE = 0; bus_b.STEP_GO = 0;
    rst_n = 0;
    repeat (2) tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL reset_sq got %0d want 0", bus_a.SQ); end
    vecs++; if (bus_a.T !== 16'h0001) begin errs++; $display("FAIL reset_t got %h want 0001", bus_a.T); end
    vecs++; if (bus_a.wrap !== 1'b0) begin errs++; $display("FAIL reset_wrap got %b want 0", bus_a.wrap); end
    vecs++; if (bus_a.err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", bus_a.err); end
    vecs++; if (bus_a.tc !== 1'b0) begin errs++; $display("FAIL reset_tc got %b want 0", bus_a.tc); end
    vecs++; if (bus_b.SQ !== 4'd0) begin errs++; $display("FAIL reset_sq_b got %0d want 0", bus_b.SQ); end
    rst_n = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL idle_sq got %0d want 0", bus_a.SQ); end
  endtask

  task automatic test_basic();
    logic [15:0] one = 16'h0001;
    logic [3:0]  exp_sq;
    bus_a.S = 1; bus_a.INR = 1; bus_a.LIMIT = 15;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_sq = 4'(i % 16);
      vecs++; if (bus_a.SQ !== exp_sq) begin errs++; $display("FAIL basic_sq[%0d] got %0d want %0d", i, bus_a.SQ, exp_sq); end
      vecs++; if (bus_a.T !== (one << exp_sq)) begin errs++; $display("FAIL basic_t[%0d] got %h want %h", i, bus_a.T, one << exp_sq); end
      vecs++; if (bus_a.wrap !== (i == 16)) begin errs++; $display("FAIL basic_wrap[%0d] got %b want %b", i, bus_a.wrap, (i == 16)); end
      vecs++; if (bus_a.tc !== (exp_sq == 4'd15)) begin errs++; $display("FAIL basic_tc[%0d] got %b want %b", i, bus_a.tc, (exp_sq == 4'd15)); end
    end
    bus_a.INR = 0;
  endtask

  task automatic test_short_limit();
    logic [3:0] exp_sq;
    bus_a.CLR = 1;
    tick();
    bus_a.CLR = 0;
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL clr_sq got %0d want 0", bus_a.SQ); end
    bus_a.LIMIT = 4; bus_a.INR = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_sq = 4'(i % 5);
      vecs++; if (bus_a.SQ !== exp_sq) begin errs++; $display("FAIL lim4_sq[%0d] got %0d want %0d", i, bus_a.SQ, exp_sq); end
      vecs++; if (bus_a.wrap !== (i == 5)) begin errs++; $display("FAIL lim4_wrap[%0d] got %b want %b", i, bus_a.wrap, (i == 5)); end
      vecs++; if (bus_a.tc !== (exp_sq == 4'd4)) begin errs++; $display("FAIL lim4_tc[%0d] got %b want %b", i, bus_a.tc, (exp_sq == 4'd4)); end
    end
    // SQ is 3 here; lowering the limit below it leaves tc low.
    bus_a.LIMIT = 2;
    #1;
    vecs++; if (bus_a.tc !== 1'b0) begin errs++; $display("FAIL lim2_tc got %b want 0", bus_a.tc); end
    tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL lim2_sq got %0d want 0", bus_a.SQ); end
    vecs++; if (bus_a.wrap !== 1'b1) begin errs++; $display("FAIL lim2_wrap got %b want 1", bus_a.wrap); end
    bus_a.INR = 0;
    tick();
    vecs++; if (bus_a.wrap !== 1'b0) begin errs++; $display("FAIL wrap_pulse got %b want 0", bus_a.wrap); end
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL hold_sq got %0d want 0", bus_a.SQ); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_sq;
    bus_b.S = 1; bus_b.INR = 1; bus_b.LIMIT = 5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_sq = (i < 5) ? 4'(i) : 4'd5;
      vecs++; if (bus_b.SQ !== exp_sq) begin errs++; $display("FAIL sat_sq[%0d] got %0d want %0d", i, bus_b.SQ, exp_sq); end
      vecs++; if (bus_b.err !== (i >= 6)) begin errs++; $display("FAIL sat_err[%0d] got %b want %b", i, bus_b.err, (i >= 6)); end
      vecs++; if (bus_b.wrap !== 1'b0) begin errs++; $display("FAIL sat_wrap[%0d] got %b want 0", i, bus_b.wrap); end
    end
    bus_b.INR = 0; bus_b.CLR = 1;
    tick();
    bus_b.CLR = 0;
    vecs++; if (bus_b.SQ !== 4'd0) begin errs++; $display("FAIL sat_clr_sq got %0d want 0", bus_b.SQ); end
    vecs++; if (bus_b.err !== 1'b0) begin errs++; $display("FAIL sat_clr_err got %b want 0", bus_b.err); end
  endtask

  task automatic test_load_priority();
    bus_a.LIMIT = 7; bus_a.LD = 1; bus_a.LD_VAL = 9;
    tick();
    vecs++; if (bus_a.SQ !== 4'd7) begin errs++; $display("FAIL ld_clamp_sq got %0d want 7", bus_a.SQ); end
    vecs++; if (bus_a.err !== 1'b1) begin errs++; $display("FAIL ld_clamp_err got %b want 1", bus_a.err); end
    bus_a.CLR = 1; bus_a.INR = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL clr_prio_sq got %0d want 0", bus_a.SQ); end
    vecs++; if (bus_a.err !== 1'b0) begin errs++; $display("FAIL clr_prio_err got %b want 0", bus_a.err); end
    bus_a.CLR = 0; bus_a.LD_VAL = 3;
    tick();
    vecs++; if (bus_a.SQ !== 4'd3) begin errs++; $display("FAIL ld_prio_sq got %0d want 3", bus_a.SQ); end
    vecs++; if (bus_a.err !== 1'b0) begin errs++; $display("FAIL ld_ok_err got %b want 0", bus_a.err); end
    bus_a.LD = 0; bus_a.INR = 0;
  endtask

  task automatic test_single_step();
    logic [3:0] exp_sq;
    bus_a.LIMIT = 15; bus_a.CLR = 1;
    tick();
    bus_a.CLR = 0;
    bus_a.STEP_MODE = 1; bus_a.INR = 1;
    // STEP_GO: high for 5 edges, low for 2, then high for 1.
    for (int k = 0; k < 8; k++) begin
      bus_a.STEP_GO = (k < 5) || (k == 7);
      tick();
      exp_sq = (k < 7) ? 4'd1 : 4'd2;
      vecs++; if (bus_a.SQ !== exp_sq) begin errs++; $display("FAIL step_sq[%0d] got %0d want %0d", k, bus_a.SQ, exp_sq); end
    end
    bus_a.STEP_GO = 0;
    tick();
    vecs++; if (bus_a.SQ !== 4'd2) begin errs++; $display("FAIL step_low_sq got %0d want 2", bus_a.SQ); end
    bus_a.S = 0; bus_a.STEP_GO = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd2) begin errs++; $display("FAIL step_s0_sq got %0d want 2", bus_a.SQ); end
    bus_a.S = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd2) begin errs++; $display("FAIL step_consumed_sq got %0d want 2", bus_a.SQ); end
    bus_a.CLR = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL step_clr_sq got %0d want 0", bus_a.SQ); end
    bus_a.CLR = 0; bus_a.STEP_GO = 0; bus_a.STEP_MODE = 0; bus_a.INR = 0;
  endtask

  task automatic test_async_reset();
    bus_a.INR = 1;
    repeat (6) tick();
    vecs++; if (bus_a.SQ !== 4'd6) begin errs++; $display("FAIL run6_sq got %0d want 6", bus_a.SQ); end
    bus_a.STEP_MODE = 1; bus_a.STEP_GO = 1;
    #2;
    rst_n = 0;
    #1;
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL async_sq got %0d want 0", bus_a.SQ); end
    vecs++; if (bus_a.T !== 16'h0001) begin errs++; $display("FAIL async_t got %h want 0001", bus_a.T); end
    repeat (2) tick();
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL rel_held_sq[%0d] got %0d want 0", k, bus_a.SQ); end
    end
    bus_a.STEP_GO = 0;
    tick();
    vecs++; if (bus_a.SQ !== 4'd0) begin errs++; $display("FAIL rel_low_sq got %0d want 0", bus_a.SQ); end
    bus_a.STEP_GO = 1;
    tick();
    vecs++; if (bus_a.SQ !== 4'd1) begin errs++; $display("FAIL rel_edge_sq got %0d want 1", bus_a.SQ); end
    bus_a.STEP_GO = 0; bus_a.INR = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_limit();
    test_saturate();
    test_load_priority();
    test_single_step();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
